// File: rtl/uart_tx_frame_pkg.sv
// Shared serial-frame definitions: state encodings for both link directions,
// frame constants and the parity helper used when a byte is latched.
package uart_tx_frame_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d,
                                        input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit, plus a look-ahead of that flag for registered outputs.
module tx_baud_tick #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end,
  output logic bit_end_nxt
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = en && (cnt_q == LAST);
    cnt_d   = cnt_q + CW'(1);
    if (clr || !en || bit_end) cnt_d = '0;
    bit_end_nxt = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Serial frame transmitter: start bit, 8 data bits MSB-first, optional parity,
// then 1 or 2 stop bits, fed by a valid/ready byte handshake.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int STOP_BITS    = 2,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       hs, bit_end, bit_end_nxt;

  assign hs = in_valid && in_ready_q;

  tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .en          (busy_q),
    .clr         (hs),
    .bit_end     (bit_end),
    .bit_end_nxt (bit_end_nxt)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    case (state_q)
      TX_IDLE: if (hs) begin
        state_d    = TX_START;
        shift_d    = in_data;
        par_d      = frame_parity(in_data, PARITY_ODD != 0);
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
      end
      TX_START: if (bit_end) begin
        state_d   = TX_DATA;
        bit_cnt_d = '0;
      end
      TX_DATA: if (bit_end) begin
        if (bit_cnt_q == LAST_DATA) begin
          state_d    = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          stop_cnt_d = 1'b0;
        end else begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      TX_PARITY: if (bit_end) begin
        state_d    = TX_STOP;
        stop_cnt_d = 1'b0;
      end
      TX_STOP: if (bit_end) begin
        if (stop_cnt_q == LAST_STOP) begin
          state_d    = TX_IDLE;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Outputs are computed from the next state so the flops line up with it.
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[7];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = LINE_IDLE;
    endcase
    done_d = (state_d == TX_STOP) && (stop_cnt_d == LAST_STOP) && bit_end_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameterisations driven with directed and
// random bytes, compared cycle by cycle against a bit-list frame model.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vld;
  logic [7:0] dat [4];
  wire  [3:0] rdy, txv, bsy, dn;

  int total = 0;
  int bad   = 0;

  int cpb [4] = '{2, 2, 1, 3};
  int pe  [4] = '{1, 1, 0, 1};
  int po  [4] = '{0, 1, 0, 0};
  int sb  [4] = '{2, 2, 1, 2};

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) d0 (
    .clk(clk), .rst(rst), .in_data(dat[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .tx(txv[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) d1 (
    .clk(clk), .rst(rst), .in_data(dat[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_frame #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) d2 (
    .clk(clk), .rst(rst), .in_data(dat[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx_frame #(.CLKS_PER_BIT(3), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) d3 (
    .clk(clk), .rst(rst), .in_data(dat[3]), .in_valid(vld[3]),
    .in_ready(rdy[3]), .tx(txv[3]), .busy(bsy[3]), .done(dn[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one byte on DUT s and checks every cycle of the frame, the idle
  // cycle after it, and a mid-bit sampling receiver's view of the line.
  task automatic run_frame(input int s, input logic [7:0] b, input bit keep,
                           input logic [7:0] nxt, input string tag, output int waited);
    logic       q[$];
    logic       obs[$];
    int         ones, len, c, h;
    logic [7:0] rxb;
    logic       refp;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) begin
      q.push_back(b[i]);
      ones += int'(b[i]);
    end
    refp = ((ones % 2) != 0) ^ (po[s] != 0);
    if (pe[s] != 0) q.push_back(refp);
    for (int i = 0; i < sb[s]; i++) q.push_back(1'b1);
    c   = cpb[s];
    h   = c / 2;
    len = q.size() * c;

    dat[s] = b;
    vld[s] = 1'b1;
    waited = 0;
    while (rdy[s] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_hs"}, rdy[s], 1);
    @(posedge clk);
    #1;
    if (!keep) vld[s] = 1'b0;
    dat[s] = nxt;

    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      obs.push_back(txv[s]);
      chk($sformatf("%s_tx%0d", tag, i + 1), txv[s], q[i / c]);
      chk($sformatf("%s_done%0d", tag, i + 1), dn[s], (i == len - 1) ? 1 : 0);
      chk($sformatf("%s_busy%0d", tag, i + 1), bsy[s], 1);
      chk($sformatf("%s_rdy%0d", tag, i + 1), rdy[s], 0);
    end
    @(negedge clk);
    chk({tag, "_idle_tx"}, txv[s], 1);
    chk({tag, "_idle_rdy"}, rdy[s], 1);
    chk({tag, "_idle_busy"}, bsy[s], 0);
    chk({tag, "_idle_done"}, dn[s], 0);

    chk({tag, "_rx_start"}, obs[h], 0);
    for (int k = 0; k < 8; k++) rxb[7 - k] = obs[(1 + k) * c + h];
    chk({tag, "_rx_byte"}, rxb, b);
    if (pe[s] != 0) chk({tag, "_rx_par"}, obs[9 * c + h], refp);
  endtask

  initial begin
    int w;
    vld = '0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), txv[i], 1);
      chk($sformatf("rst_rdy%0d", i), rdy[i], 1);
      chk($sformatf("rst_busy%0d", i), bsy[i], 0);
      chk($sformatf("rst_done%0d", i), dn[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 8'hA5, 1'b0, 8'h00, "a5", w);
    run_frame(0, 8'h01, 1'b0, 8'h00, "par_even", w);
    run_frame(1, 8'h01, 1'b0, 8'h00, "par_odd", w);

    run_frame(0, 8'h3C, 1'b1, 8'hC3, "b2b_a", w);
    run_frame(0, 8'hC3, 1'b0, 8'h00, "b2b_b", w);
    chk("b2b_gap", w, 0);

    // Abandon a frame of 0xFF in data bit 4 with an asynchronous reset.
    dat[0] = 8'hFF;
    vld[0] = 1'b1;
    w = 0;
    while (rdy[0] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("mid_hs", rdy[0], 1);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_busy_before", bsy[0], 1);
    chk("mid_rdy_before", rdy[0], 0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", txv[0], 1);
    chk("mid_rst_busy", bsy[0], 0);
    chk("mid_rst_done", dn[0], 0);
    chk("mid_rst_rdy", rdy[0], 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("mid_post_done%0d", i), dn[0], 0);
      chk($sformatf("mid_post_tx%0d", i), txv[0], 1);
    end
    chk("mid_post_rdy", rdy[0], 1);
    run_frame(0, 8'h55, 1'b0, 8'h00, "after_rst", w);

    run_frame(2, 8'h80, 1'b0, 8'h00, "cpb1", w);
    run_frame(2, 8'h5A, 1'b0, 8'h00, "cpb1_b", w);

    for (int n = 0; n < 50; n++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      run_frame(3, rb, 1'b0, 8'($urandom), $sformatf("lb%0d", n), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial frame transmitter. It is the transmit-side counterpart of the team's serial byte receiver.
- Accepts one byte per valid/ready handshake and drives it on a single line `tx`: start bit, 8 data bits MSB-first, optional parity bit, then stop bits.
- Sits between a byte producer (register file, test driver) and the serial pin. Intended for loopback against the receiver.

Parameters:
- CLKS_PER_BIT, 2: clk cycles per serial bit. Legal range is 1 or more.
- STOP_BITS, 2: number of stop bit-times. Legal values are 1 or 2.
- PARITY_EN, 1: 1 inserts a parity bit after the data bits; 0 omits it.
- PARITY_ODD, 0: 0 means parity bit = XOR of data bits (even). 1 means its inverse (odd).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  8  byte to send. Sampled only on handshake.
- in_valid  in  1  producer has a byte.
- in_ready  out  1  block can accept a byte this cycle.
- tx  out  1  serial line. Idle level is 1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on the final clk cycle of the last stop bit.

Behaviour:
- Reset values (asynchronous, held while rst=1): tx=1, in_ready=1, busy=0, done=0, state=IDLE, counters=0, shift register=0.
- All outputs are registered. `tx` never glitches.
- Handshake: a transfer occurs at a rising edge where in_valid=1 and in_ready=1.
  - At that edge: latch in_data and its parity, set in_ready=0, set busy=1, enter START.
  - tx goes to 0 in the cycle after the edge (1-cycle latency).
  - in_valid while in_ready=0 is ignored. in_data changes after the handshake have no effect.
- Bit timing: a per-bit counter counts 0..CLKS_PER_BIT-1. Each bit holds tx for exactly CLKS_PER_BIT cycles.
- States:
  - IDLE: tx=1, in_ready=1. On handshake, go to START.
  - START: tx=0 for one bit-time, then go to DATA.
  - DATA: tx = shift register MSB. Shift left once per bit-time. A bit counter counts 0..7. After the 8th bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = ^data XOR PARITY_ODD for one bit-time, then go to STOP.
  - STOP: tx=1 for STOP_BITS bit-times.
    - On the last cycle of the last stop bit: done=1.
    - Next cycle: IDLE, in_ready=1, busy=0, done=0.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles from the first tx=0 cycle to the done cycle, inclusive.
- Back-to-back: IDLE lasts at least 1 cycle. The earliest next handshake is the cycle after done, so the minimum gap between frames is one idle cycle (tx=1).
- CLKS_PER_BIT=1: every state advances each cycle. There is no special case.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). The partial frame is abandoned and done is not pulsed. After rst falls, the block is in IDLE with in_ready=1.
- Counters never wrap in normal operation. Bit and stop counters are cleared on each state entry.

Decomposition:
- Shared include holds:
  - TX state encodings IDLE/START/DATA/PARITY/STOP, alongside the existing receiver state defines, with distinct names.
  - Frame constants DATA_BITS=8 and the idle line level.
- One sub-module: `tx_baud_tick`. It is a counter 0..CLKS_PER_BIT-1 with a synchronous clear on frame start and a one-cycle `bit_end` output.
- The main module holds the FSM, shift register, parity and handshake.

Test Plan:
- 0xA5, defaults (CLKS_PER_BIT=2, parity even, 2 stop):
  - Expected tx per cycle: 0,0, 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1, 0,0, 1,1,1,1. Parity=0.
  - done high on cycle 24 only. in_ready=1 on cycle 25.
- 0x01, PARITY_EN=1:
  - Parity bit = 1 (even).
  - With PARITY_ODD=1: parity bit = 0, and the frame is otherwise identical.
- Back-to-back 0x3C then 0xC3 with in_valid held high:
  - Exactly one idle cycle between frames.
  - The second frame starts 2 cycles after the first done. Both bytes serialize correctly.
  - in_data changed mid-frame does not corrupt the first frame.
- Reset mid-frame: assert rst during DATA bit 4 of 0xFF.
  - tx=1 in the same cycle. busy=0. No done pulse.
  - After release, send 0x55 and check the full correct frame.
- PARITY_EN=0, STOP_BITS=1, CLKS_PER_BIT=1, byte 0x80:
  - tx sequence: 0, 1,0,0,0,0,0,0,0, 1.
  - done on the 10th cycle.
- Loopback into the team's receiver with CLKS_PER_BIT=3 (mid-bit sampling) and random bytes x50:
  - Received out equals sent byte.
  - Receiver par matches an independent reference parity computation.
